// File: rtl/dev_input_uart_pkg.sv
// Shared constants and state encodings for the UART tape-input feeder.
package dev_input_uart_pkg;
  localparam int unsigned UART_BIT_COUNT = 8;
  localparam int unsigned CODE_WIDTH     = 5;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
  typedef enum logic {H_IDLE, H_VALID} hs_state_t;
endpackage

// File: rtl/dev_input_uart_rx.sv
// 8N1 UART receiver: input synchroniser, baud counter and RX FSM.
module uart_rx_8n1
  import dev_input_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      uart_rx,
  output logic [UART_BIT_COUNT-1:0] rx_byte,
  output logic                      byte_valid,
  output logic                      frame_err
);
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] HALF_CNT = BW'(CLKS_PER_BIT / 2);
  localparam logic [BW-1:0] LAST_CNT = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT = 3'(UART_BIT_COUNT - 1);

  rx_state_t                 state;
  logic                      rx_meta;
  logic                      rx_sync;
  logic [BW-1:0]             baud_cnt;
  logic [2:0]                bit_cnt;
  logic [UART_BIT_COUNT-1:0] shreg;
  logic                      break_wait;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      break_wait <= 1'b0;
    end else begin
      rx_meta    <= uart_rx;
      rx_sync    <= rx_meta;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_sync) begin
            state    <= START;
            baud_cnt <= '0;
            bit_cnt  <= '0;
          end
        end
        START: begin
          if (baud_cnt == HALF_CNT) begin
            baud_cnt <= '0;
            state    <= rx_sync ? IDLE : DATA;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        DATA: begin
          if (baud_cnt == LAST_CNT) begin
            baud_cnt <= '0;
            shreg    <= {rx_sync, shreg[UART_BIT_COUNT-1:1]};
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == LAST_BIT) state <= STOP;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        STOP: begin
          // After a framing error, park here until the line idles high so a
          // held break is not re-read as a stream of start bits.
          if (break_wait) begin
            if (rx_sync) begin
              break_wait <= 1'b0;
              state      <= IDLE;
            end
          end else if (baud_cnt == LAST_CNT) begin
            baud_cnt <= '0;
            if (rx_sync) begin
              rx_byte    <= shreg;
              byte_valid <= 1'b1;
              state      <= IDLE;
            end else begin
              frame_err  <= 1'b1;
              break_wait <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/dev_input_uart.sv
// Host-PC UART feeder for the tape-input channel: code filter, character FIFO
// and four-phase level handshake towards the core.
module dev_input_uart
  import dev_input_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        uart_rx,
  input  logic                        dev_input_rdy,
  output logic                        dev_input_val,
  output logic [CODE_WIDTH-1:0]       dev_input_data,
  input  logic                        clr_status,
  output logic                        sts_overflow,
  output logic                        sts_frame_err,
  output logic                        sts_bad_code,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int unsigned PW   = $clog2(FIFO_DEPTH);
  localparam int unsigned LVLW = PW + 1;
  localparam logic [LVLW-1:0] FULL_LVL = LVLW'(FIFO_DEPTH);

  logic [UART_BIT_COUNT-1:0] rx_byte;
  logic                      byte_valid;
  logic                      frame_err;

  uart_rx_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .resetn     (resetn),
    .uart_rx    (uart_rx),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  logic [CODE_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  hs_state_t             hs_state;

  logic code_ok, push_req, bad_evt, pop, fifo_full, push, ovf_evt;

  // A pop in the same cycle frees the head slot, so a full FIFO still accepts.
  always_comb begin
    code_ok   = (rx_byte[UART_BIT_COUNT-1:CODE_WIDTH] == '0);
    push_req  = byte_valid && code_ok;
    bad_evt   = byte_valid && !code_ok;
    pop       = (hs_state == H_VALID) && !dev_input_rdy;
    fifo_full = (fifo_level == FULL_LVL);
    push      = push_req && (!fifo_full || pop);
    ovf_evt   = push_req && fifo_full && !pop;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= rx_byte[CODE_WIDTH-1:0];
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVLW'(1);
        2'b01:   fifo_level <= fifo_level - LVLW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hs_state       <= H_IDLE;
      dev_input_val  <= 1'b0;
      dev_input_data <= '0;
    end else begin
      case (hs_state)
        H_IDLE: begin
          if ((fifo_level != '0) && dev_input_rdy) begin
            dev_input_data <= mem[rd_ptr];
            dev_input_val  <= 1'b1;
            hs_state       <= H_VALID;
          end
        end
        H_VALID: begin
          if (!dev_input_rdy) begin
            dev_input_val <= 1'b0;
            hs_state      <= H_IDLE;
          end
        end
        default: hs_state <= H_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sts_overflow  <= 1'b0;
      sts_frame_err <= 1'b0;
      sts_bad_code  <= 1'b0;
    end else begin
      sts_overflow  <= ovf_evt   | (sts_overflow  & ~clr_status);
      sts_frame_err <= frame_err | (sts_frame_err & ~clr_status);
      sts_bad_code  <= bad_evt   | (sts_bad_code  & ~clr_status);
    end
  end
endmodule
